// File: rtl/switch_node_4rad.sv
`default_nettype none
// ============================================================================
// Module      : switch_node_4rad
// Description : Radix-4 wormhole switch node, per-output round-robin, one
//               register stage, no buffering. Losing packets are dropped.
//               Optional SWN_ROUTE_SHIFT_EN rotates forwarded head data by 2.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_node_4rad #(
    parameter int FLIT_W = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0][FLIT_W-1:0] in_ch,
    output logic [3:0][FLIT_W-1:0] out_ch
);

    localparam int         NPORT   = 4;
    localparam logic [1:0] ST_FREE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;
    localparam logic [1:0] T_HEAD  = 2'b11;
    localparam logic [1:0] T_BODY  = 2'b10;

    logic [NPORT-1:0][1:0]        state_q,  state_d;
    logic [NPORT-1:0][1:0]        dest_q,   dest_d;
    logic [NPORT-1:0][1:0]        rr_ptr_q, rr_ptr_d;
    logic [NPORT-1:0][FLIT_W-1:0] out_ch_q, out_ch_d;

    logic [NPORT-1:0][1:0]        w_type;
    logic [NPORT-1:0][1:0]        w_digit;
    logic [NPORT-1:0]             w_is_head;
    logic [NPORT-1:0][FLIT_W-1:0] w_head_fwd;
    logic [NPORT-1:0]             w_alloc;
    logic [NPORT-1:0][1:0]        w_owner;
    logic [NPORT-1:0]             w_grant_vld;
    logic [NPORT-1:0][1:0]        w_grant_idx;
    logic [NPORT-1:0]             w_in_granted;

    for (genvar i = 0; i < NPORT; i++) begin : g_in
        assign w_type[i]    = in_ch[i][FLIT_W-1 -: 2];
        assign w_digit[i]   = in_ch[i][FLIT_W-3 -: 2];
        assign w_is_head[i] = (w_type[i] == T_HEAD);
`ifdef SWN_ROUTE_SHIFT_EN
        // Next stage's digit lands in the routing position.
        assign w_head_fwd[i] = {in_ch[i][FLIT_W-1 -: 2], in_ch[i][FLIT_W-5:0],
                                in_ch[i][FLIT_W-3 -: 2]};
`else
        assign w_head_fwd[i] = in_ch[i];
`endif
    end

    // Allocation is derived from registered input state, so an output
    // released this cycle still looks busy until the next one.
    always_comb begin
        w_alloc = '0;
        w_owner = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (state_q[i] == ST_FWD) begin
                w_alloc[dest_q[i]] = 1'b1;
                w_owner[dest_q[i]] = 2'(i);
            end
        end
    end

    always_comb begin
        logic [1:0] cand;
        cand        = '0;
        w_grant_vld = '0;
        w_grant_idx = '0;
        rr_ptr_d    = rr_ptr_q;
        for (int d = 0; d < NPORT; d++) begin
            for (int k = 0; k < NPORT; k++) begin
                cand = rr_ptr_q[d] + 2'(k);
                if (!w_grant_vld[d] && !w_alloc[d] && w_is_head[cand] &&
                    (w_digit[cand] == 2'(d))) begin
                    w_grant_vld[d] = 1'b1;
                    w_grant_idx[d] = cand;
                end
            end
            if (w_grant_vld[d]) begin
                rr_ptr_d[d] = w_grant_idx[d] + 2'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        dest_d       = dest_q;
        w_in_granted = '0;
        for (int d = 0; d < NPORT; d++) begin
            if (w_grant_vld[d]) begin
                w_in_granted[w_grant_idx[d]] = 1'b1;
            end
        end
        for (int i = 0; i < NPORT; i++) begin
            if (w_is_head[i]) begin
                state_d[i] = w_in_granted[i] ? ST_FWD : ST_DROP;
                if (w_in_granted[i]) begin
                    dest_d[i] = w_digit[i];
                end
            end else begin
                case (state_q[i])
                    ST_FWD:  if (w_type[i] != T_BODY) state_d[i] = ST_FREE;
                    ST_DROP: if (w_type[i] != T_BODY) state_d[i] = ST_FREE;
                    default: state_d[i] = ST_FREE;
                endcase
            end
        end
    end

    // A head arriving on the owning input ends the old packet with no flit.
    always_comb begin
        out_ch_d = '0;
        for (int d = 0; d < NPORT; d++) begin
            if (w_grant_vld[d]) begin
                out_ch_d[d] = w_head_fwd[w_grant_idx[d]];
            end else if (w_alloc[d] && !w_is_head[w_owner[d]]) begin
                out_ch_d[d] = in_ch[w_owner[d]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= {NPORT{ST_FREE}};
            dest_q   <= '0;
            rr_ptr_q <= '0;
            out_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            rr_ptr_q <= rr_ptr_d;
            out_ch_q <= out_ch_d;
        end
    end

    assign out_ch = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_node_4rad.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_node_4rad
// Description : Directed bench for switch_node_4rad with a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_node_4rad;

    localparam int FLIT_W = 18;

    logic                   clk    = 1'b0;
    logic                   rst_n  = 1'b0;
    logic [3:0][FLIT_W-1:0] in_ch  = '0;
    logic [3:0][FLIT_W-1:0] out_ch;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    switch_node_4rad #(.FLIT_W(FLIT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_ch  (in_ch),
        .out_ch (out_ch)
    );

    always #5 clk = ~clk;

    // Model: mode 0=free 1=forwarding 2=dropping; owner -1 = output unallocated.
    int                m_mode [4];
    int                m_dst  [4];
    int                m_owner[4];
    int                m_rr   [4];
    logic [FLIT_W-1:0] exp_out[4];

    function automatic logic [FLIT_W-1:0] head_out(input logic [FLIT_W-1:0] f);
`ifdef SWN_ROUTE_SHIFT_EN
        logic [FLIT_W-3:0] data;
        logic [FLIT_W-3:0] rot;
        data = f[FLIT_W-3:0];
        rot  = (data << 2) | (data >> (FLIT_W - 4));
        return {f[FLIT_W-1:FLIT_W-2], rot};
`else
        return f;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int                nmode[4];
        int                ndst [4];
        int                nown [4];
        int                nrr  [4];
        logic [FLIT_W-1:0] nout [4];
        bit                got  [4];
        int                t;
        int                win;
        int                cand;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                m_mode[k]  <= 0;
                m_dst[k]   <= 0;
                m_owner[k] <= -1;
                m_rr[k]    <= 0;
                exp_out[k] <= '0;
            end
        end else begin
            nmode = m_mode;
            ndst  = m_dst;
            nown  = m_owner;
            nrr   = m_rr;
            for (int k = 0; k < 4; k++) begin
                nout[k] = '0;
                got[k]  = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                t = int'(in_ch[i][FLIT_W-1 -: 2]);
                if (m_mode[i] == 1) begin
                    if (t != 3) nout[m_dst[i]] = in_ch[i];
                    if (t != 2) begin
                        nown[m_dst[i]] = -1;
                        nmode[i]       = 0;
                    end
                end else if (m_mode[i] == 2 && t != 2) begin
                    nmode[i] = 0;
                end
            end
            for (int d = 0; d < 4; d++) begin
                if (m_owner[d] < 0) begin
                    win = -1;
                    for (int k = 0; k < 4; k++) begin
                        cand = (m_rr[d] + k) % 4;
                        if (win < 0 && in_ch[cand][FLIT_W-1 -: 2] == 2'b11 &&
                            int'(in_ch[cand][FLIT_W-3 -: 2]) == d)
                            win = cand;
                    end
                    if (win >= 0) begin
                        nown[d]    = win;
                        nmode[win] = 1;
                        ndst[win]  = d;
                        nrr[d]     = (win + 1) % 4;
                        nout[d]    = head_out(in_ch[win]);
                        got[win]   = 1'b1;
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (in_ch[i][FLIT_W-1 -: 2] == 2'b11 && !got[i]) nmode[i] = 2;
            end
            for (int k = 0; k < 4; k++) begin
                m_mode[k]  <= nmode[k];
                m_dst[k]   <= ndst[k];
                m_owner[k] <= nown[k];
                m_rr[k]    <= nrr[k];
                exp_out[k] <= nout[k];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (out_ch[d] !== exp_out[d]) begin
                    failures++;
                    $display("FAIL model_out%0d t=%0t got=%h exp=%h", d, $time, out_ch[d], exp_out[d]);
                end
            end
        end
    end

    task automatic lit(input string name, input int d, input logic [FLIT_W-1:0] e);
        checks++;
        if (out_ch[d] !== e) begin
            failures++;
            $display("FAIL %s: out_ch[%0d] got=%h exp=%h", name, d, out_ch[d], e);
        end
    endtask

    task automatic step(input logic [FLIT_W-1:0] a, input logic [FLIT_W-1:0] b,
                        input logic [FLIT_W-1:0] c, input logic [FLIT_W-1:0] e);
        @(negedge clk);
        in_ch[0] = a;
        in_ch[1] = b;
        in_ch[2] = c;
        in_ch[3] = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_ch = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;

        // Idle after reset
        repeat (3) step('0, '0, '0, '0);
        lit("reset_idle0", 0, '0);
        lit("reset_idle3", 3, '0);

        // Single packet from input 3 to output 0
        step('0, '0, '0, 18'h30000);
        lit("single_head", 0, 18'h30000);
        lit("single_other", 1, '0);
        step('0, '0, '0, 18'h2DEAD);
        lit("single_body", 0, 18'h2DEAD);
        step('0, '0, '0, '0);
        lit("single_idle", 0, '0);

        // Full permutation
        step(18'h3C000, 18'h38000, 18'h34000, 18'h30000);
        step(18'h2BEEF, 18'h2DEFE, 18'h2CA7E, 18'h2F00D);
        lit("perm_out3", 3, 18'h2BEEF);
        lit("perm_out2", 2, 18'h2DEFE);
        lit("perm_out1", 1, 18'h2CA7E);
        lit("perm_out0", 0, 18'h2F00D);
        step('0, '0, '0, '0);

        // Contention on output 1, round robin across two rounds
        do_reset();
        step(18'h34000, '0, 18'h34000, '0);
        step(18'h2AAAA, '0, 18'h2BBBB, '0);
        lit("rr_first_in0", 1, 18'h2AAAA);
        step('0, '0, '0, '0);
        lit("rr_release", 1, '0);
        step(18'h34000, '0, 18'h34000, '0);
        step(18'h2CCCC, '0, 18'h2DDDD, '0);
        lit("rr_second_in2", 1, 18'h2DDDD);
        step('0, '0, '0, '0);

        // Busy output drops a late head; regrant the cycle after the tail
        step('0, 18'h38000, '0, '0);
        step('0, 18'h21111, '0, 18'h38000);
        lit("busy_keep", 2, 18'h21111);
        step('0, 18'h22222, '0, 18'h23333);
        lit("busy_drop_body", 2, 18'h22222);
        step('0, 18'h18BAD, '0, '0);
        lit("busy_tail", 2, 18'h18BAD);
        step('0, '0, '0, 18'h38000);
        step('0, '0, '0, 18'h24444);
        lit("regrant_body", 2, 18'h24444);
        step('0, '0, '0, 18'h10000);
        step('0, '0, '0, '0);

        // Head while forwarding releases the output but cannot regrant it
        step(18'h30000, '0, '0, '0);
        step(18'h30000, '0, '0, '0);
        lit("fwd_head_release", 0, '0);
        step(18'h2FFFF, '0, '0, '0);
        lit("drop_body", 0, '0);
        step('0, '0, '0, '0);
        step(18'h30000, '0, '0, '0);
        lit("after_drop_head", 0, 18'h30000);
        step('0, '0, '0, '0);

        // Asynchronous reset mid-packet
        step('0, 18'h30000, '0, '0);
        step('0, 18'h2ABCD, '0, '0);
        lit("pre_reset_body", 0, 18'h2ABCD);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        lit("async_reset", 0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step('0, 18'h21234, '0, '0);
        lit("post_reset_body", 0, '0);
        step('0, '0, '0, '0);

        // Head data rotation
        step('0, 18'h36000, '0, '0);
`ifdef SWN_ROUTE_SHIFT_EN
        lit("head_rotate", 1, 18'h38001);
`else
        lit("head_exact", 1, 18'h36000);
`endif
        step('0, '0, '0, '0);
        repeat (2) step('0, '0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
